dram_addr_sequencer: RTL and testbench

Parametrised DRAM address multiplexer and RAS/CAS sequencer, the clocked successor to the quad 2:1 tristate address mux parts on the chip-RAM path. It latches a full row+column address on request, drives row then column onto a shared tristate MA bus, and generates the `_RAS`, `_CAS` and `_WE` strobes with programmable cycle counts. It also runs CAS-before-RAS refresh cycles. It sits between the bus arbiter and the DRAM array.

---
 rtl/dram_seq_pkg.sv | 31 +++
 rtl/dram_addr_sequencer_if.sv | 26 ++
 rtl/addr_mux_tri.sv | 12 +
 rtl/dram_addr_sequencer.sv | 130 +++++++++++++
 tb/tb_dram_addr_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dram_seq_pkg.sv
// rtl/dram_seq_pkg.sv - shared state encoding and counter sizing for the DRAM sequencer
package dram_seq_pkg;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_RAS     = 3'd1;
    localparam logic [2:0] ENC_COL     = 3'd2;
    localparam logic [2:0] ENC_CAS     = 3'd3;
    localparam logic [2:0] ENC_PRE     = 3'd4;
    localparam logic [2:0] ENC_REF_CAS = 3'd5;
    localparam logic [2:0] ENC_REF_RAS = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_RAS     = ENC_RAS,
        ST_COL     = ENC_COL,
        ST_CAS     = ENC_CAS,
        ST_PRE     = ENC_PRE,
        ST_REF_CAS = ENC_REF_CAS,
        ST_REF_RAS = ENC_REF_RAS
    } dram_state_t;

    // One spare bit keeps the width sane when the largest count is a power of two.
    function automatic int cnt_width(input int t_rcd, input int t_cas, input int t_rp);
        int m;
        m = t_rcd;
        if (t_cas > m) m = t_cas;
        if (t_rp > m) m = t_rp;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/dram_addr_sequencer_if.sv
// rtl/dram_addr_sequencer_if.sv - request/strobe bundle between arbiter, sequencer and DRAM
interface dram_addr_sequencer_if #(
    parameter int AW = 9
);
    logic            REQ;
    logic [2*AW-1:0] ADDR;
    logic            RW;
    logic            REFRESH;
    logic            _RAS;
    logic            _CAS;
    logic            _WE;
    logic            SEL;
    logic            ACK;
    logic            RFACK;
    logic            BUSY;

    modport master (
        output REQ, ADDR, RW, REFRESH,
        input  _RAS, _CAS, _WE, SEL, ACK, RFACK, BUSY
    );

    modport slave (
        input  REQ, ADDR, RW, REFRESH,
        output _RAS, _CAS, _WE, SEL, ACK, RFACK, BUSY
    );
endinterface

// File: rtl/addr_mux_tri.sv
// rtl/addr_mux_tri.sv - W-bit 2:1 mux with active-low tristate output enable
module addr_mux_tri #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sel_i,
    input  logic         oe_n_i,
    output wire  [W-1:0] y_o
);
    assign y_o = oe_n_i ? {W{1'bz}} : (sel_i ? b_i : a_i);
endmodule

// File: rtl/dram_addr_sequencer.sv
// rtl/dram_addr_sequencer.sv - DRAM row/column address mux with RAS/CAS/WE and CBR refresh sequencing
module dram_addr_sequencer
    import dram_seq_pkg::*;
#(
    parameter int AW    = 9,
    parameter int T_RCD = 1,
    parameter int T_CAS = 2,
    parameter int T_RP  = 2
) (
    input  logic                 CLK,
    input  logic                 _RESET,
    dram_addr_sequencer_if.slave bus,
    input  logic                 _OE,
    output wire  [AW-1:0]        MA
);
    localparam int CW = cnt_width(T_RCD, T_CAS, T_RP);
    localparam logic [CW-1:0] RCD_LD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] CAS_LD = CW'(T_CAS - 1);
    localparam logic [CW-1:0] RP_LD  = CW'(T_RP - 1);

    dram_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] row_q, row_d, col_q, col_d;
    logic          rw_q, rw_d;
    logic          ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
    logic          sel_q, sel_d, ack_q, ack_d, rfack_q, rfack_d, busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        rw_d    = rw_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.REFRESH) begin
                    state_d = ST_REF_CAS;
                end else if (bus.REQ) begin
                    state_d = ST_RAS;
                    cnt_d   = RCD_LD;
                    row_d   = bus.ADDR[2*AW-1:AW];
                    col_d   = bus.ADDR[AW-1:0];
                    rw_d    = bus.RW;
                end
            end
            ST_RAS: begin
                if (cnt_q == '0) state_d = ST_COL;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_COL: begin
                state_d = ST_CAS;
                cnt_d   = CAS_LD;
            end
            ST_CAS, ST_REF_RAS: begin
                if (cnt_q == '0) begin
                    state_d = ST_PRE;
                    cnt_d   = RP_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_REF_CAS: begin
                state_d = ST_REF_RAS;
                cnt_d   = CAS_LD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the flops present them glitch-free.
    always_comb begin
        ras_n_d = !(state_d inside {ST_RAS, ST_COL, ST_CAS, ST_REF_RAS});
        cas_n_d = !(state_d inside {ST_CAS, ST_REF_CAS, ST_REF_RAS});
        sel_d   = state_d inside {ST_COL, ST_CAS};
        we_n_d  = sel_d ? rw_d : 1'b1;
        ack_d   = (state_d == ST_CAS) && (cnt_d == '0);
        rfack_d = (state_d == ST_REF_RAS) && (cnt_d == '0);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rw_q    <= 1'b1;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            sel_q   <= 1'b0;
            ack_q   <= 1'b0;
            rfack_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rw_q    <= rw_d;
            ras_n_q <= ras_n_d;
            cas_n_q <= cas_n_d;
            we_n_q  <= we_n_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            rfack_q <= rfack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus._RAS  = ras_n_q;
    assign bus._CAS  = cas_n_q;
    assign bus._WE   = we_n_q;
    assign bus.SEL   = sel_q;
    assign bus.ACK   = ack_q;
    assign bus.RFACK = rfack_q;
    assign bus.BUSY  = busy_q;

    addr_mux_tri #(.W(AW)) u_mux (
        .a_i    (row_q),
        .b_i    (col_q),
        .sel_i  (sel_q),
        .oe_n_i (_OE),
        .y_o    (MA)
    );
endmodule

// File: tb/tb_dram_addr_sequencer.sv
// tb/tb_dram_addr_sequencer.sv - bench for dram_addr_sequencer: default and swept timing instances
module tb_dram_addr_sequencer;
    localparam int AW = 9;
    localparam int K_NONE = 0;
    localparam int K_ACC  = 1;
    localparam int K_REF  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            oe_n = 1'b0;
    logic [2*AW-1:0] addr = '0;
    logic            rw = 1'b1;
    logic [1:0]      req = '0;
    logic [1:0]      rfr = '0;
    wire  [AW-1:0]   ma_a, ma_b;

    int checks = 0;
    int errors = 0;

    int            m_kind [2];
    int            m_k    [2];
    logic [AW-1:0] m_row  [2];
    logic [AW-1:0] m_col  [2];
    logic          m_rw   [2];

    always #5 clk = ~clk;

    dram_addr_sequencer_if #(.AW(AW)) if_a ();
    dram_addr_sequencer_if #(.AW(AW)) if_b ();

    assign if_a.REQ = req[0];
    assign if_a.REFRESH = rfr[0];
    assign if_a.ADDR = addr;
    assign if_a.RW = rw;
    assign if_b.REQ = req[1];
    assign if_b.REFRESH = rfr[1];
    assign if_b.ADDR = addr;
    assign if_b.RW = rw;

    dram_addr_sequencer #(.AW(AW), .T_RCD(1), .T_CAS(2), .T_RP(2)) dut_a (
        .CLK(clk), ._RESET(rst_n), .bus(if_a.slave), ._OE(oe_n), .MA(ma_a));
    dram_addr_sequencer #(.AW(AW), .T_RCD(3), .T_CAS(1), .T_RP(1)) dut_b (
        .CLK(clk), ._RESET(rst_n), .bus(if_b.slave), ._OE(oe_n), .MA(ma_b));

    wire [6:0] obs_a = {if_a._RAS, if_a._CAS, if_a._WE, if_a.SEL, if_a.ACK, if_a.RFACK, if_a.BUSY};
    wire [6:0] obs_b = {if_b._RAS, if_b._CAS, if_b._WE, if_b.SEL, if_b.ACK, if_b.RFACK, if_b.BUSY};

    function automatic int p_rcd(input int d); return (d == 0) ? 1 : 3; endfunction
    function automatic int p_cas(input int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int p_rp (input int d); return (d == 0) ? 2 : 1; endfunction

    function automatic int op_len(input int d);
        if (m_kind[d] == K_ACC) return p_rcd(d) + p_cas(d) + p_rp(d) + 2;
        if (m_kind[d] == K_REF) return p_cas(d) + p_rp(d) + 2;
        return 0;
    endfunction

    // Expected {_RAS,_CAS,_WE,SEL,ACK,RFACK,BUSY} for cycle k of the current operation.
    function automatic logic [6:0] exp_vec(input int d);
        int k, rcd, cas, last;
        logic ras_n, cas_n, we_n, sel, ack, rfack, busy;
        k = m_k[d]; rcd = p_rcd(d); cas = p_cas(d);
        ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1; sel = 1'b0;
        ack = 1'b0; rfack = 1'b0; busy = 1'b0;
        if (m_kind[d] == K_ACC) begin
            last  = rcd + 1 + cas;
            busy  = (k >= 1) && (k < op_len(d));
            ras_n = !((k >= 1) && (k <= last));
            cas_n = !((k >= rcd + 2) && (k <= last));
            sel   = (k >= rcd + 1) && (k <= last);
            we_n  = m_rw[d] | !sel;
            ack   = (k == last);
        end else if (m_kind[d] == K_REF) begin
            busy  = (k >= 1) && (k < op_len(d));
            cas_n = !((k >= 1) && (k <= 1 + cas));
            ras_n = !((k >= 2) && (k <= 1 + cas));
            rfack = (k == 1 + cas);
        end
        return {ras_n, cas_n, we_n, sel, ack, rfack, busy};
    endfunction

    function automatic logic [AW-1:0] exp_ma(input int d);
        logic [6:0] e;
        e = exp_vec(d);
        return e[3] ? m_col[d] : m_row[d];
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_strobes"}, 18'(obs_a), 18'(exp_vec(0)));
        chk({tag, "_b_strobes"}, 18'(obs_b), 18'(exp_vec(1)));
        if (!oe_n) begin
            chk({tag, "_a_ma"}, 18'(ma_a), 18'(exp_ma(0)));
            chk({tag, "_b_ma"}, 18'(ma_b), 18'(exp_ma(1)));
        end
    endtask

    task automatic model_edge(input int d);
        if (!rst_n) begin
            m_kind[d] = K_NONE;
            m_k[d] = 0;
        end else if (m_kind[d] == K_NONE || m_k[d] >= op_len(d)) begin
            m_k[d] = 1;
            if (rfr[d]) begin
                m_kind[d] = K_REF;
            end else if (req[d]) begin
                m_kind[d] = K_ACC;
                m_row[d] = addr[2*AW-1:AW];
                m_col[d] = addr[AW-1:0];
                m_rw[d] = rw;
            end else begin
                m_kind[d] = K_NONE;
            end
        end else begin
            m_k[d]++;
        end
    endtask

    // One clock: advance the model at the edge, check the DUTs 1 ns later, then
    // let each requester drop its line in the cycle its acknowledge is due.
    task automatic step(input string tag);
        logic [6:0] e;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        check_all(tag);
        for (int d = 0; d < 2; d++) begin
            e = exp_vec(d);
            if (e[2]) req[d] = 1'b0;
            if (e[1]) rfr[d] = 1'b0;
        end
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        req = '0;
        rfr = '0;
        for (int d = 0; d < 2; d++) begin
            m_kind[d] = K_NONE; m_k[d] = 0;
            m_row[d] = '0; m_col[d] = '0; m_rw[d] = 1'b1;
        end
    endtask

    initial begin
        #1;
        assert_reset();
        #1;
        check_all("reset");
        step("reset_hold");
        step("reset_hold");
        rst_n = 1'b1;

        addr = {9'h152, 9'h0F3};
        rw = 1'b1;
        req = 2'b11;
        for (int c = 1; c <= 7; c++) begin
            step("read");
            if (c == 1) chk("read_ma_row", 18'(ma_a), 18'h152);
            if (c == 2) chk("read_ma_col", 18'(ma_a), 18'h0F3);
            if (c == 4) chk("read_ack_c4", 18'(if_a.ACK), 18'h1);
            if (c == 5) chk("sweep_ack_c5", 18'(if_b.ACK), 18'h1);
            if (c == 7) chk("read_idle_c7", {16'h0, if_a.BUSY, if_b.BUSY}, 18'h0);
        end

        oe_n = 1'b1;
        #1;
        checks++;
        assert (!(ma_a === 9'h152)) else begin
            errors++;
            $error("FAIL oe_release observed=%h expected=released", ma_a);
        end
        oe_n = 1'b0;

        rw = 1'b0;
        req = 2'b11;
        for (int c = 1; c <= 7; c++) begin
            step("write");
            if (c == 2) begin
                addr = 18'($urandom);
                rw = 1'b1;
            end
            if (c == 3) chk("write_we_c3", 18'(if_a._WE), 18'h0);
        end

        req = 2'b11;
        rfr = 2'b11;
        for (int c = 1; c <= 14; c++) begin
            step("ref_vs_req");
            if (c == 3) chk("ref_rfack_c3", 18'(if_a.RFACK), 18'h1);
            if (c == 7) chk("ref_then_ras_c7", 18'(if_a._RAS), 18'h0);
        end

        addr = 18'($urandom);
        req = 2'b11;
        for (int c = 1; c <= 3; c++) step("pre_abort");
        assert_reset();
        #1;
        check_all("abort");
        step("abort_hold");
        step("abort_hold");
        rst_n = 1'b1;
        req = 2'b11;
        for (int c = 1; c <= 9; c++) step("restart");

        for (int c = 0; c < 200; c++) begin
            addr = 18'($urandom);
            rw = 1'($urandom);
            for (int d = 0; d < 2; d++) begin
                if (!req[d] && !rfr[d]) begin
                    case ($urandom_range(0, 7))
                        0: rfr[d] = 1'b1;
                        1, 2: req[d] = 1'b1;
                        default: ;
                    endcase
                end
            end
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
